cordic_rotation_iter: RTL
=========================

# cordic_rotation_iter

Iterative CORDIC core in rotation mode. It rotates an input vector (x, y) by a signed angle z and returns the rotated vector scaled by the CORDIC gain K ≈ 1.6468. It is the inverse-direction companion to the vectoring-mode datapath: vectoring turns (x, y) into magnitude and angle, while this block turns angle plus vector back into (x, y), i.e. sin/cos generation. One micro-rotation runs per clock, and the block uses the same arithmetic right shift by a variable amount as the vectoring path.

## Interface
- WORD_WIDTH, 16: width of x, y and z words; legal range 16..32.
- SHIFT_WIDTH, 4: width of the iteration index / shift amount.
- ITERATIONS, 16: number of micro-rotations; must satisfy ITERATIONS ≤ 2^SHIFT_WIDTH and ITERATIONS ≤ WORD_WIDTH.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x_in  in  WORD_WIDTH  signed vector x.
- y_in  in  WORD_WIDTH  signed vector y.
- z_in  in  WORD_WIDTH  signed angle in binary angle units: 2^(WORD_WIDTH-1) = π, so 16384 = π/2 at W=16.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; results valid.
- x_out  out  WORD_WIDTH  signed K·(x·cos z − y·sin z).
- y_out  out  WORD_WIDTH  signed K·(x·sin z + y·cos z).

## Operation
- States: IDLE, PRE (only when the macro is defined), ITER, DONE.
- IDLE → PRE/ITER on start=1:
  - Register x_in, y_in and z_in.
  - Clear the iteration counter i to 0.
  - Assert busy.
- PRE: one-cycle quadrant correction (see Configuration), then → ITER.
- ITER, one micro-rotation per cycle at index i:
  - d = +1 if z ≥ 0, else −1.
  - x ← x − d·(y >>> i).
  - y ← y + d·(x >>> i), using the old x.
  - z ← z − d·atan[i].
  - i increments each cycle; when i = ITERATIONS−1 the state goes → DONE.
- DONE:
  - Load x_out and y_out (truncated to WORD_WIDTH).
  - done=1 and busy=0 for one cycle, then → IDLE.
- Arithmetic:
  - `>>>` is an arithmetic (sign-preserving) shift.
  - Internal x and y registers are WORD_WIDTH+1 bits; z is WORD_WIDTH+1 bits.
- atan ROM:
  - Holds atan(2^-i) in binary angle units as 32-bit constants (π = 2^31), right-shifted by 32−WORD_WIDTH.
  - W=16 values: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- Input range: the caller guarantees sqrt(x²+y²)·1.65 < 2^(WORD_WIDTH-1). Outside this range the output wraps and is not checked.
- start while busy, or in the DONE cycle: ignored, no queueing.
- x_out and y_out hold their values until the next DONE.

## Timing
- Reset values: state IDLE, busy=0, done=0, x_out=0, y_out=0, i=0.
- Latency from the start-sampling edge to the done pulse:
  - Without macro: ITERATIONS+1 cycles (17 at defaults).
  - With macro: ITERATIONS+2 cycles (18 at defaults).
- Back-to-back: start may be asserted in the cycle after done; it is accepted in IDLE. Throughput is one result per ITERATIONS+2 (+1 with macro) cycles.
- rst=1 mid-operation: at the next edge the block returns to IDLE and clears busy, done, x_out and y_out. The aborted operation produces no done.
- rst and start high together: rst wins, and start is not accepted.

## Configuration
- Macro: CORDIC_QUAD_CORR_EN.
- Defined: the PRE state exists and is always traversed (one cycle), and the full angle range [−π, π) is supported.
  - If z > 2^(W-2): x ← −y, y ← x, z ← z − 2^(W-2).
  - If z < −2^(W-2): x ← y, y ← −x, z ← z + 2^(W-2).
  - Otherwise registers are unchanged.
- Undefined: there is no PRE state, and results are valid only for |z| ≤ 2^(W-2) (±π/2).

## Test plan
All checks at defaults with tolerance ±3 LSB.

- Reset: rst=1 for 2 cycles → busy=0, done=0, x_out=0, y_out=0.
- Zero angle: x=1000, y=0, z=0, start → done at 17 cycles (18 with macro), x_out≈1647, y_out≈0.
- π/4 rotation:
  - x=1000, y=0, z=8192 → x_out≈1164, y_out≈1164.
  - x=1000, y=0, z=−16384 → x_out≈0, y_out≈−1647.
- Quadrant correction, with macro only: x=1000, y=0, z=−32768 → x_out≈−1647, y_out≈0; z=24576 → x_out≈−1164, y_out≈1164.
- Protocol:
  - start pulsed again at cycle 5 of busy → ignored, single done.
  - rst at cycle 8 of busy → no done, outputs 0.
  - A new start after reset completes normally.

Source files
------------

// File: rtl/cordic_rotation_iter.sv
// -----------------------------------------------------------------------------
// cordic_rotation_iter
// Iterative rotation-mode CORDIC: rotates (x_in, y_in) by angle z_in and
// returns the vector scaled by the CORDIC gain K ~= 1.6468. One micro-rotation
// per clock. Angles are binary angle units, 2^(WORD_WIDTH-1) = pi.
//
// Ports
//   clk    : rising-edge clock
//   rst    : synchronous active-high reset
//   start  : request, sampled only in IDLE
//   x_in   : signed vector x
//   y_in   : signed vector y
//   z_in   : signed rotation angle
//   busy   : high from the cycle after start is accepted until done
//   done   : one-cycle pulse, x_out/y_out valid
//   x_out  : K*(x*cos z - y*sin z)
//   y_out  : K*(x*sin z + y*cos z)
//
// Optional feature macro: CORDIC_QUAD_CORR_EN
//   Adds a one-cycle PRE state that folds |z| > pi/2 into range by a
//   +/-90 degree pre-rotation, giving the full [-pi, pi) angle range.
//
// state  | meaning
// IDLE   | waiting for start
// PRE    | quadrant correction (macro only)
// ITER   | one micro-rotation per cycle, index i
// DONE   | load outputs, done pulse issued next cycle
// -----------------------------------------------------------------------------
module cordic_rotation_iter #(
    parameter int WORD_WIDTH  = 16,
    parameter int SHIFT_WIDTH = 4,
    parameter int ITERATIONS  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] x_in,
    input  logic [WORD_WIDTH-1:0] y_in,
    input  logic [WORD_WIDTH-1:0] z_in,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_WIDTH-1:0] x_out,
    output logic [WORD_WIDTH-1:0] y_out
);

    localparam int XW = WORD_WIDTH + 1;
    localparam logic [SHIFT_WIDTH-1:0] LAST_I = SHIFT_WIDTH'(ITERATIONS - 1);
    localparam logic signed [XW-1:0] QUARTER = {2'b00, 1'b1, {(WORD_WIDTH-2){1'b0}}};
    // Round-to-nearest when narrowing the 32-bit table to WORD_WIDTH.
    localparam int          RND_SH = (WORD_WIDTH < 32) ? (31 - WORD_WIDTH) : 0;
    localparam logic [32:0] RND    = (WORD_WIDTH < 32) ? (33'd1 << RND_SH) : 33'd0;

`ifdef CORDIC_QUAD_CORR_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_PRE = 2'd1, S_ITER = 2'd2, S_DONE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd2, S_DONE = 2'd3} state_t;
`endif

    // atan(2^-k) with pi = 2^31.
    function automatic logic signed [XW-1:0] atan_lut(input logic [SHIFT_WIDTH-1:0] idx);
        logic [4:0]  k;
        logic [31:0] c;
        logic [32:0] r;
        k = 5'(idx);
        case (k)
            5'd0:  c = 32'd536870912;
            5'd1:  c = 32'd316933406;
            5'd2:  c = 32'd167458907;
            5'd3:  c = 32'd85004756;
            5'd4:  c = 32'd42667331;
            5'd5:  c = 32'd21354465;
            5'd6:  c = 32'd10679838;
            5'd7:  c = 32'd5340245;
            5'd8:  c = 32'd2670163;
            5'd9:  c = 32'd1335087;
            5'd10: c = 32'd667544;
            5'd11: c = 32'd333772;
            5'd12: c = 32'd166886;
            5'd13: c = 32'd83443;
            5'd14: c = 32'd41722;
            5'd15: c = 32'd20861;
            5'd16: c = 32'd10430;
            5'd17: c = 32'd5215;
            5'd18: c = 32'd2608;
            5'd19: c = 32'd1304;
            5'd20: c = 32'd652;
            5'd21: c = 32'd326;
            5'd22: c = 32'd163;
            5'd23: c = 32'd81;
            5'd24: c = 32'd41;
            5'd25: c = 32'd20;
            5'd26: c = 32'd10;
            5'd27: c = 32'd5;
            5'd28: c = 32'd3;
            5'd29: c = 32'd1;
            5'd30: c = 32'd1;
            default: c = 32'd0;
        endcase
        r = ({1'b0, c} + RND) >> (32 - WORD_WIDTH);
        return XW'(r);
    endfunction

    state_t                  state_q, state_d;
    logic signed [XW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
    logic [SHIFT_WIDTH-1:0]  i_q, i_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [WORD_WIDTH-1:0]   x_out_q, x_out_d, y_out_q, y_out_d;
    logic signed [XW-1:0]    x_sh, y_sh, atan_i;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        x_sh    = x_q >>> i_q;
        y_sh    = y_q >>> i_q;
        atan_i  = atan_lut(i_q);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d    = XW'($signed(x_in));
                    y_d    = XW'($signed(y_in));
                    z_d    = XW'($signed(z_in));
                    i_d    = '0;
                    busy_d = 1'b1;
`ifdef CORDIC_QUAD_CORR_EN
                    state_d = S_PRE;
`else
                    state_d = S_ITER;
`endif
                end
            end
`ifdef CORDIC_QUAD_CORR_EN
            S_PRE: begin
                // +/-90 degree pre-rotation so ITER only sees |z| <= pi/2.
                if (z_q > QUARTER) begin
                    x_d = -y_q;
                    y_d = x_q;
                    z_d = z_q - QUARTER;
                end else if (z_q < -QUARTER) begin
                    x_d = y_q;
                    y_d = -x_q;
                    z_d = z_q + QUARTER;
                end
                state_d = S_ITER;
            end
`endif
            S_ITER: begin
                if (!z_q[XW-1]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_i;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_i;
                end
                i_d = i_q + 1'b1;
                if (i_q == LAST_I) state_d = S_DONE;
            end
            S_DONE: begin
                x_out_d = x_q[WORD_WIDTH-1:0];
                y_out_d = y_q[WORD_WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            x_out_q <= '0;
            y_out_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            x_out_q <= x_out_d;
            y_out_q <= y_out_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign x_out = x_out_q;
    assign y_out = y_out_q;

endmodule
